mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
// - Shares the single-port data RAM and the GPIO register space between two requesters:
//   m0 = core data port, m1 = debug/boot loader port.
// - Sits between the requesters and the RAM/GPIO split.
// - Owns the address decode: addr < RAM_DEPTH goes to RAM; addr >= RAM_DEPTH goes to GPIO.
// - Sequences each access through a registered IDLE/ACCESS/RESP FSM.
//   RAM read latency is 1 cycle; GPIO reads use the same timing.
// PARAMETERS
// - ADDR_W     11    requester address width
// - DATA_W     32    data width
// - RAM_DEPTH  1024  RAM words; also the GPIO base address; RAM address width = $clog2(RAM_DEPTH)
// PORTS
// - CLK            in   1          system clock, rising edge
// - RST_n          in   1          asynchronous reset, active low
// - m0_req         in   1          m0 request; held with addr/we/wdata until m0_gnt
// - m0_we          in   1          m0 write(1) / read(0)
// - m0_addr        in   ADDR_W     m0 word address
// - m0_wdata       in   DATA_W     m0 write data
// - m0_gnt         out  1          m0 request accepted this cycle
// - m0_rvalid      out  1          m0 read data valid, 1-cycle pulse
// - m0_rdata       out  DATA_W     m0 read data, valid with m0_rvalid
// - m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata
//                                  same as m0_* for requester m1
// - ram_en         out  1          RAM access strobe
// - ram_we         out  1          RAM write enable
// - ram_addr       out  clog2(RAM_DEPTH)  RAM address
// - ram_wdata      out  DATA_W     RAM write data
// - ram_rdata      in   DATA_W     RAM read data, valid 1 cycle after ram_en
// - gpio_we        out  1          GPIO register write strobe
// - gpio_wdata     out  DATA_W     GPIO write data
// - gpio_rdata     in   DATA_W     GPIO register value (combinational)
// - busy           out  1          FSM not in IDLE
// BEHAVIOUR
// - Clock and reset: one clock, CLK. RST_n is asynchronous, active low.
// - Reset values:
//   - state = IDLE; RR pointer favours m0.
//   - All outputs 0; latched addr/wdata/we/owner = 0.
// - IDLE:
//   - m0_gnt/m1_gnt are combinational. At most one is high, and only while in IDLE with its req high.
//   - On the grant edge, latch addr/we/wdata/owner; go to ACCESS.
// - ACCESS (1 cycle):
//   - RAM target: ram_en=1, ram_we=we, ram_addr=addr[clog2(RAM_DEPTH)-1:0], ram_wdata=wdata.
//   - GPIO target: gpio_we=we, gpio_wdata=wdata; ram_en=0. A GPIO read samples gpio_rdata into the rdata register.
//   - Write: return to IDLE. Read: go to RESP.
// - RESP (1 cycle):
//   - Owner's rvalid=1. rdata = ram_rdata (RAM) or the sampled GPIO value; return to IDLE.
// - Latency, grant at cycle T:
//   - Access strobe at T+1.
//   - Read rvalid at T+2.
//   - Next grant at T+3 after a read, T+2 after a write.
// - Write handling: writes never produce rvalid.
// - rdata hold: the non-owner rdata holds its previous value.
// - Strobes: ram_en and gpio_we are single-cycle pulses; ram_we is never high without ram_en.
// - Arbitration: both req high in IDLE -> fixed priority, m0 wins.
// - Requests are sampled only in IDLE:
//   - req arriving during ACCESS/RESP waits.
//   - req dropped before gnt: no access.
// - Address boundaries:
//   - addr = RAM_DEPTH-1 -> RAM.
//   - addr = RAM_DEPTH -> GPIO.
//   - Addresses >= RAM_DEPTH all alias the GPIO register.
// - Reset mid-transaction: access aborted, no rvalid issued, FSM to IDLE.
// CONFIGURATION
// - ARB_RR_EN defined:
//   - Round-robin arbitration; a 1-bit pointer updates on every grant.
//   - On a simultaneous request, the requester NOT granted last wins.
// - ARB_RR_EN undefined:
//   - Fixed priority, m0 > m1; m1 can starve; no pointer flop.
// TESTING
// - Reset during a read in ACCESS (RST_n=0) -> all outputs 0 immediately; no rvalid after release; busy=0.
// - m0 write 0x005 = 0xDEADBEEF, gnt at T
//   -> ram_en=ram_we=1, ram_addr=0x005 at T+1.
//   -> Then m1 read 0x005: m1_rvalid at T'+2, m1_rdata=0xDEADBEEF.
// - m0 write 0x400 = 0x000000AA -> gpio_we 1-cycle pulse, gpio_wdata=0xAA, ram_en=0.
//   -> Read 0x400 with gpio_rdata=0xAA: rvalid, rdata=0x000000AA.
// - m0 read 0x3FF -> RAM (ram_addr=0x3FF); m0 read 0x7FF -> GPIO, ram_en stays 0.
// - m0_req and m1_req held high with reads:
//   -> ARB_RR_EN undefined: grants m0,m0,m0.
//   -> ARB_RR_EN defined: grants m0,m1,m0,m1 at T, T+3, T+6, T+9.
// - m0 back-to-back reads 0x001, 0x002 -> gnt at T and T+3; rvalid at T+2 and T+5; data in order.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter sharing the data RAM and the GPIO register; addr >= RAM_DEPTH selects GPIO.
// Latency: grant at T (comb), access strobe at T+1, read rvalid at T+2; next grant T+3 (read) / T+2 (write).
// Backpressure: requesters hold req/addr/we/wdata until gnt; requests are sampled only while idle.
// Build option: define ARB_RR_EN for round-robin arbitration (default is fixed priority, m0 > m1).
module mem_bus_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int RAM_DEPTH = 1024
) (
  input  logic                         CLK,
  input  logic                         RST_n,
  input  logic                         m0_req,
  input  logic                         m0_we,
  input  logic [ADDR_W-1:0]            m0_addr,
  input  logic [DATA_W-1:0]            m0_wdata,
  output logic                         m0_gnt,
  output logic                         m0_rvalid,
  output logic [DATA_W-1:0]            m0_rdata,
  input  logic                         m1_req,
  input  logic                         m1_we,
  input  logic [ADDR_W-1:0]            m1_addr,
  input  logic [DATA_W-1:0]            m1_wdata,
  output logic                         m1_gnt,
  output logic                         m1_rvalid,
  output logic [DATA_W-1:0]            m1_rdata,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
  output logic [DATA_W-1:0]            ram_wdata,
  input  logic [DATA_W-1:0]            ram_rdata,
  output logic                         gpio_we,
  output logic [DATA_W-1:0]            gpio_wdata,
  input  logic [DATA_W-1:0]            gpio_rdata,
  output logic                         busy
);

  localparam int RAW = $clog2(RAM_DEPTH);
  // One extra bit so a GPIO base equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] GPIO_BASE = (ADDR_W+1)'(RAM_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t              r_state;
  logic [RAW-1:0]      r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic                r_owner;     // 0 = m0, 1 = m1
  logic                r_gpio;      // latched target decode
  logic [DATA_W-1:0]   r_gpio_q;    // GPIO value sampled during a read access
  logic                r_ram_en;
  logic                r_ram_we;
  logic                r_gpio_we;
  logic                r_m0_rvalid;
  logic                r_m1_rvalid;
  logic [DATA_W-1:0]   r_m0_rdata;  // last delivered data, held between responses
  logic [DATA_W-1:0]   r_m1_rdata;

  logic                w_idle;
  logic                w_gnt0;
  logic                w_gnt1;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_we;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_to_gpio;
  logic [DATA_W-1:0]   w_rd_src;

  assign w_idle = (r_state == ST_IDLE);

`ifdef ARB_RR_EN
  logic r_prio_m1;  // 1 when m1 wins a tie (m0 was granted last); reset favours m0

  // Round-robin pointer: flips toward the requester that was not just served
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_prio_m1 <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_prio_m1 <= w_gnt0;
    end
  end

  assign w_gnt0 = w_idle & m0_req & (~m1_req | ~r_prio_m1);
  assign w_gnt1 = w_idle & m1_req & (~m0_req |  r_prio_m1);
`else
  assign w_gnt0 = w_idle & m0_req;
  assign w_gnt1 = w_idle & m1_req & ~m0_req;
`endif

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;

  assign w_addr    = w_gnt1 ? m1_addr  : m0_addr;
  assign w_we      = w_gnt1 ? m1_we    : m0_we;
  assign w_wdata   = w_gnt1 ? m1_wdata : m0_wdata;
  assign w_to_gpio = ({1'b0, w_addr} >= GPIO_BASE);

  // RAM data arrives one cycle after ram_en, i.e. exactly in RESP, so it is passed straight through
  assign w_rd_src  = r_gpio ? r_gpio_q : ram_rdata;

  // Access sequencer: latch the granted request, pulse the strobes, then deliver read data
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_owner     <= 1'b0;
      r_gpio      <= 1'b0;
      r_gpio_q    <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_gpio_we   <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_ram_en  <= 1'b0;
      r_ram_we  <= 1'b0;
      r_gpio_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_addr    <= w_addr[RAW-1:0];
            r_wdata   <= w_wdata;
            r_we      <= w_we;
            r_owner   <= w_gnt1;
            r_gpio    <= w_to_gpio;
            r_ram_en  <= ~w_to_gpio;
            r_ram_we  <= ~w_to_gpio & w_we;
            r_gpio_we <= w_to_gpio & w_we;
            r_state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_gpio && !r_we) begin
            r_gpio_q <= gpio_rdata;
          end
          if (r_we) begin
            r_state <= ST_IDLE;
          end else begin
            r_m0_rvalid <= ~r_owner;
            r_m1_rvalid <= r_owner;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_m0_rvalid <= 1'b0;
          r_m1_rvalid <= 1'b0;
          if (r_m0_rvalid) r_m0_rdata <= w_rd_src;
          if (r_m1_rvalid) r_m1_rdata <= w_rd_src;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ram_en     = r_ram_en;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_addr;
  assign ram_wdata  = r_wdata;
  assign gpio_we    = r_gpio_we;
  assign gpio_wdata = r_wdata;
  assign m0_rvalid  = r_m0_rvalid;
  assign m1_rvalid  = r_m1_rvalid;
  assign m0_rdata   = r_m0_rvalid ? w_rd_src : r_m0_rdata;
  assign m1_rdata   = r_m1_rvalid ? w_rd_src : r_m1_rdata;
  assign busy       = (r_state != ST_IDLE);

endmodule
